wb_pwm_esc: RTL and testbench

Wishbone slave with four PWM channels that drive the quadcopter ESCs. It sits directly downstream of the shared-bus decoder on one slave port and consumes its address, data, select, we, cyc and stb signals, returning read data and ack. Duty and period writes are staged and applied only at a PWM period boundary, so no glitched pulses reach the motors. A throttle watchdog forces the minimum-throttle duty if software stops refreshing the duties.

---
 rtl/wb_pwm_esc_if.sv | 36 +++
 rtl/wb_pwm_esc.sv | 239 +++++++++++++++++++++++
 tb/tb_wb_pwm_esc.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pwm_esc_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_pwm_esc_if
// Wishbone classic bus bundle between the shared-bus decoder (master side) and
// the ESC PWM block (slave side).
//   wb_adr_i  32  byte address (block decodes [4:2])
//   wb_dat_i  32  write data
//   wb_dat_o  32  registered read data
//   wb_cti_i   3  cycle type (not used by the slave)
//   wb_sel_i   4  byte selects
//   wb_we_i    1  write enable
//   wb_cyc_i   1  cycle
//   wb_stb_i   1  strobe
//   wb_ack_o   1  acknowledge
// -----------------------------------------------------------------------------
interface wb_pwm_esc_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [2:0]  wb_cti_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_cti_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_cti_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_pwm_esc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_pwm_esc
// Wishbone slave driving four quadcopter ESC PWM channels. Prescale, period
// and duty writes land in a staging copy and are transferred to the active
// copy only at a PWM period end (or on the next edge while disabled), so a
// pulse is never cut short or stretched by a mid-period update. A throttle
// watchdog forces every duty to RST_DUTY if software stops writing duties.
//
// Ports:
//   sys_clk   system clock
//   sys_rst   asynchronous active-low reset
//   wb        Wishbone slave bundle (see wb_pwm_esc_if)
//   pwm_o     ESC outputs, channel i on bit i (registered)
//
// Register map (word offset adr[4:2]):
//   0 CTRL     bit0 EN, bit1 POL
//   1 PRESCALE [15:0]
//   2 PERIOD   [15:0]
//   3..6 DUTY0..DUTY3 [15:0]
//   7 STATUS   bit0 pending, bit1 wdt_trip, [31:16] PWM counter (read only)
// -----------------------------------------------------------------------------
module wb_pwm_esc #(
   parameter logic [15:0] RST_PRESCALE = 16'd49,
   parameter logic [15:0] RST_PERIOD   = 16'd19999,
   parameter logic [15:0] RST_DUTY     = 16'd1000,
   parameter logic [7:0]  WDT_PERIODS  = 8'd25
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   wb_pwm_esc_if.slave wb,
   output logic [3:0]  pwm_o
);
   localparam int NCH = 4;

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESCALE = 3'd1;
   localparam logic [2:0] OFF_PERIOD   = 3'd2;
   localparam logic [2:0] OFF_DUTY0    = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd7;

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [15:0] pre_s_q, pre_s_d, pre_a_q, pre_a_d;
   logic [15:0] per_s_q, per_s_d, per_a_q, per_a_d;
   logic        pending_q, pending_d;
   logic        wdt_trip_q, wdt_trip_d;
   logic [7:0]  wdt_cnt_q, wdt_cnt_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [15:0] cnt_q, cnt_d;

   logic [NCH-1:0][15:0] duty_s_rd;

   logic [2:0] off;
   logic       access, wr;
   logic       en, pol;
   logic       tick, period_end, load;
   logic       duty_wr, stage_wr, wdt_fire;

   // Byte-lane merge for the 16-bit fields; sel[3:2] never matter.
   function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                           input logic [15:0] new_val,
                                           input logic [1:0]  be);
      return {be[1] ? new_val[15:8] : old_val[15:8],
              be[0] ? new_val[7:0]  : old_val[7:0]};
   endfunction

   // Bus bits the block deliberately ignores.
   logic unused_bus;
   assign unused_bus = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16],
                         wb.wb_sel_i[3:2], wb.wb_cti_i};

   assign off    = wb.wb_adr_i[4:2];
   // Holding off while ack is high makes back-to-back strobes ack every other cycle.
   assign access = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   assign wr     = access & wb.wb_we_i;
   assign en     = ctrl_q[0];
   assign pol    = ctrl_q[1];

   assign duty_wr  = wr & (off >= OFF_DUTY0) & (off != OFF_STATUS);
   assign stage_wr = wr & (off != OFF_CTRL) & (off != OFF_STATUS);

   assign tick       = en & (pcnt_q == pre_a_q);
   assign period_end = tick & (cnt_q == per_a_q);
   // Disabled: staging follows on the edge after a write, so pending is the trigger.
   assign load       = en ? period_end : pending_q;
   // Fires on the period end that brings the watchdog count up to WDT_PERIODS.
   assign wdt_fire   = en & period_end & ~duty_wr & (wdt_cnt_q == WDT_PERIODS - 8'd1);

   always_comb begin
      ack_d      = access;
      dat_d      = 32'd0;
      ctrl_d     = ctrl_q;
      pre_s_d    = pre_s_q;
      per_s_d    = per_s_q;
      pre_a_d    = pre_a_q;
      per_a_d    = per_a_q;
      pending_d  = pending_q;
      wdt_trip_d = wdt_trip_q;
      wdt_cnt_d  = wdt_cnt_q;
      pcnt_d     = pcnt_q;
      cnt_d      = cnt_q;

      if (access && !wb.wb_we_i) begin
         case (off)
            3'd0: dat_d = {30'd0, ctrl_q};
            3'd1: dat_d = {16'd0, pre_s_q};
            3'd2: dat_d = {16'd0, per_s_q};
            3'd3: dat_d = {16'd0, duty_s_rd[0]};
            3'd4: dat_d = {16'd0, duty_s_rd[1]};
            3'd5: dat_d = {16'd0, duty_s_rd[2]};
            3'd6: dat_d = {16'd0, duty_s_rd[3]};
            3'd7: dat_d = {cnt_q, 14'd0, wdt_trip_q, pending_q};
         endcase
      end

      if (wr && (off == OFF_CTRL) && wb.wb_sel_i[0]) begin
         ctrl_d = wb.wb_dat_i[1:0];
      end
      if (wr && (off == OFF_PRESCALE)) begin
         pre_s_d = merge16(pre_s_q, wb.wb_dat_i[15:0], wb.wb_sel_i[1:0]);
      end
      if (wr && (off == OFF_PERIOD)) begin
         per_s_d = merge16(per_s_q, wb.wb_dat_i[15:0], wb.wb_sel_i[1:0]);
      end

      // Load copies the pre-write staging value; a coincident write keeps pending set.
      if (load) begin
         pre_a_d = pre_s_q;
         per_a_d = per_s_q;
      end
      if (stage_wr) begin
         pending_d = 1'b1;
      end else if (load) begin
         pending_d = 1'b0;
      end

      if (!en) begin
         pcnt_d = 16'd0;
         cnt_d  = 16'd0;
      end else if (tick) begin
         pcnt_d = 16'd0;
         cnt_d  = period_end ? 16'd0 : cnt_q + 16'd1;
      end else begin
         pcnt_d = pcnt_q + 16'd1;
      end

      // Watchdog count saturates at WDT_PERIODS so it trips once per silence.
      if (!en || duty_wr) begin
         wdt_cnt_d = 8'd0;
      end else if (period_end && (wdt_cnt_q != WDT_PERIODS)) begin
         wdt_cnt_d = wdt_cnt_q + 8'd1;
      end
      if (wdt_fire) begin
         wdt_trip_d = 1'b1;
      end else if (duty_wr) begin
         wdt_trip_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         ack_q      <= 1'b0;
         dat_q      <= 32'd0;
         ctrl_q     <= 2'd0;
         pre_s_q    <= RST_PRESCALE;
         per_s_q    <= RST_PERIOD;
         pre_a_q    <= RST_PRESCALE;
         per_a_q    <= RST_PERIOD;
         pending_q  <= 1'b0;
         wdt_trip_q <= 1'b0;
         wdt_cnt_q  <= 8'd0;
         pcnt_q     <= 16'd0;
         cnt_q      <= 16'd0;
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         ctrl_q     <= ctrl_d;
         pre_s_q    <= pre_s_d;
         per_s_q    <= per_s_d;
         pre_a_q    <= pre_a_d;
         per_a_q    <= per_a_d;
         pending_q  <= pending_d;
         wdt_trip_q <= wdt_trip_d;
         wdt_cnt_q  <= wdt_cnt_d;
         pcnt_q     <= pcnt_d;
         cnt_q      <= cnt_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;

   // Per-channel duty staging/active pair and registered output.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [2:0] CH_OFF = OFF_DUTY0 + 3'(gi);

      logic [15:0] duty_s_q, duty_s_d;
      logic [15:0] duty_a_q, duty_a_d;
      logic        pwm_q, pwm_d;
      logic        ch_wr;

      assign ch_wr = wr & (off == CH_OFF);

      always_comb begin
         duty_s_d = duty_s_q;
         duty_a_d = duty_a_q;
         if (ch_wr) begin
            duty_s_d = merge16(duty_s_q, wb.wb_dat_i[15:0], wb.wb_sel_i[1:0]);
         end
         if (load) begin
            duty_a_d = duty_s_q;
         end
         // Watchdog wins over a same-edge load: motors go to minimum throttle.
         if (wdt_fire) begin
            duty_s_d = RST_DUTY;
            duty_a_d = RST_DUTY;
         end
         pwm_d = en ? ((cnt_q < duty_a_q) ^ pol) : pol;
      end

      always_ff @(posedge sys_clk or negedge sys_rst) begin
         if (!sys_rst) begin
            duty_s_q <= RST_DUTY;
            duty_a_q <= RST_DUTY;
            pwm_q    <= 1'b0;
         end else begin
            duty_s_q <= duty_s_d;
            duty_a_q <= duty_a_d;
            pwm_q    <= pwm_d;
         end
      end

      assign duty_s_rd[gi] = duty_s_q;
      assign pwm_o[gi]     = pwm_q;
   end

endmodule

// File: tb/tb_wb_pwm_esc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wb_pwm_esc
// Self-checking bench for wb_pwm_esc: a table of bus vectors with expected
// read data, plus hand-written sequences for PWM shape, glitch-free update,
// watchdog and mid-operation reset. One line is printed per bus transaction.
// -----------------------------------------------------------------------------
module tb_wb_pwm_esc;
   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic [3:0] pwm_o;

   wb_pwm_esc_if bus ();

   wb_pwm_esc dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wb      (bus),
      .pwm_o   (pwm_o)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;
   int pulses[$];
   int run_len = 0;

   typedef struct packed {
      logic        we;
      logic [2:0]  off;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] mask;   // 0 = no read-data comparison
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic we, input logic [2:0] off, input logic [31:0] wdat,
                               input logic [3:0] sel, input logic [31:0] mask, input logic [31:0] exp);
      vec_t v;
      v.we = we; v.off = off; v.wdat = wdat; v.sel = sel; v.mask = mask; v.exp = exp;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // One classic access; ack must follow exactly one edge after the strobe.
   task automatic xfer(input logic we, input logic [2:0] off, input logic [31:0] wdat,
                       input logic [3:0] sel, output logic [31:0] rdat);
      int lat;
      @(negedge sys_clk);
      bus.wb_adr_i = {27'd0, off, 2'b00};
      bus.wb_dat_i = wdat;
      bus.wb_sel_i = sel;
      bus.wb_we_i  = we;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      lat = 0;
      do begin
         @(posedge sys_clk);
         #1;
         lat++;
      end while ((bus.wb_ack_o !== 1'b1) && (lat < 8));
      rdat = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      $display("%0t %s off=%0d wdat=0x%08h sel=%b rdat=0x%08h lat=%0d",
               $time, we ? "WR" : "RD", off, wdat, sel, rdat, lat);
      check("ack_latency", 32'(lat), 32'd1);
      @(posedge sys_clk);   // let ack drop before the next access
   endtask

   task automatic run_vecs(input int lo, input int hi);
      logic [31:0] rd;
      for (int i = lo; i < hi; i++) begin
         xfer(vecs[i].we, vecs[i].off, vecs[i].wdat, vecs[i].sel, rd);
         if (vecs[i].mask != 32'd0) begin
            check($sformatf("vec%0d_off%0d", i, vecs[i].off), rd & vecs[i].mask, vecs[i].exp);
         end
      end
   endtask

   task automatic wait_rise(input int ch, output logic ok);
      logic prev;
      prev = pwm_o[ch];
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge sys_clk);
         if (!prev && pwm_o[ch]) begin
            ok = 1'b1;
            break;
         end
         prev = pwm_o[ch];
      end
   endtask

   // Records completed high-pulse lengths on channel 0, sampled on negedges.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (pwm_o[0]) begin
            run_len++;
         end else begin
            if (run_len > 0) pulses.push_back(run_len);
            run_len = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int s_rst, s_t2, s_t4, s_t5, s_end;
      logic [31:0] rd;
      logic ok;
      logic [3:0] b2b_pat;
      int cnt_hi[4];
      int n;

      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_cti_i = '0;
      bus.wb_sel_i = '0;
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      sys_rst      = 1'b0;

      // Reset-value reads.
      s_rst = vecs.size();
      add(0, 3'd0, 0, 4'hF, 32'hFFFF_FFFF, 32'd0);
      add(0, 3'd1, 0, 4'hF, 32'hFFFF_FFFF, 32'd49);
      add(0, 3'd2, 0, 4'hF, 32'hFFFF_FFFF, 32'd19999);
      add(0, 3'd3, 0, 4'hF, 32'hFFFF_FFFF, 32'd1000);
      add(0, 3'd4, 0, 4'hF, 32'hFFFF_FFFF, 32'd1000);
      add(0, 3'd5, 0, 4'hF, 32'hFFFF_FFFF, 32'd1000);
      add(0, 3'd6, 0, 4'hF, 32'hFFFF_FFFF, 32'd1000);
      add(0, 3'd7, 0, 4'hF, 32'hFFFF_FFFF, 32'd0);
      // Basic PWM setup: prescale 0, period 9, duties 3/0/10, then enable.
      s_t2 = vecs.size();
      add(1, 3'd1, 32'd0,  4'b0011, 0, 0);
      add(1, 3'd2, 32'd9,  4'b0011, 0, 0);
      add(1, 3'd3, 32'd3,  4'b0011, 0, 0);
      add(1, 3'd4, 32'd0,  4'b0011, 0, 0);
      add(1, 3'd5, 32'd10, 4'b0011, 0, 0);
      add(0, 3'd1, 0, 4'hF, 32'hFFFF_FFFF, 32'd0);
      add(0, 3'd2, 0, 4'hF, 32'hFFFF_FFFF, 32'd9);
      add(0, 3'd5, 0, 4'hF, 32'hFFFF_FFFF, 32'd10);
      add(0, 3'd4, 0, 4'hF, 32'hFFFF_FFFF, 32'd0);
      add(1, 3'd0, 32'd1,  4'b0001, 0, 0);
      // Byte selects and ignored writes.
      s_t4 = vecs.size();
      add(1, 3'd6, 32'h0000_1234, 4'b1111, 0, 0);
      add(1, 3'd6, 32'h0000_ABCD, 4'b0001, 0, 0);
      add(0, 3'd6, 0, 4'hF, 32'hFFFF_FFFF, 32'h0000_12CD);
      add(1, 3'd6, 32'h0000_5600, 4'b0010, 0, 0);
      add(0, 3'd6, 0, 4'hF, 32'hFFFF_FFFF, 32'h0000_56CD);
      add(1, 3'd6, 32'hFFFF_0000, 4'b1100, 0, 0);
      add(0, 3'd6, 0, 4'hF, 32'hFFFF_FFFF, 32'h0000_56CD);
      add(1, 3'd7, 32'hFFFF_FFFF, 4'b1111, 0, 0);
      add(0, 3'd0, 0, 4'hF, 32'hFFFF_FFFF, 32'd1);
      add(1, 3'd0, 32'd2, 4'b0000, 0, 0);
      add(0, 3'd0, 0, 4'hF, 32'hFFFF_FFFF, 32'd1);
      add(0, 3'd7, 0, 4'hF, 32'h0000_0002, 32'd0);
      // Watchdog recovery: a duty write clears the trip flag.
      s_t5 = vecs.size();
      add(1, 3'd3, 32'd2, 4'b0011, 0, 0);
      add(0, 3'd7, 0, 4'hF, 32'h0000_0002, 32'd0);
      add(0, 3'd3, 0, 4'hF, 32'hFFFF_FFFF, 32'd2);
      s_end = vecs.size();

      // --- Reset state ---
      repeat (3) @(posedge sys_clk);
      #1;
      check("pwm_in_reset", 32'(pwm_o), 32'd0);
      check("ack_in_reset", 32'(bus.wb_ack_o), 32'd0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      run_vecs(s_rst, s_t2);
      check("pwm_after_reset", 32'(pwm_o), 32'd0);

      // --- Held strobe: ack every other cycle ---
      b2b_pat = 4'b0101;
      @(negedge sys_clk);
      bus.wb_adr_i = {27'd0, 3'd1, 2'b00};
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge sys_clk);
         #1;
         $display("%0t RD-HELD off=1 ack=%0b rdat=0x%08h", $time, bus.wb_ack_o, bus.wb_dat_o);
         check($sformatf("b2b_ack%0d", k), 32'(bus.wb_ack_o), 32'(b2b_pat[k]));
         if (k == 0) check("b2b_data", bus.wb_dat_o, 32'd49);
      end
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;

      // --- Basic PWM ---
      run_vecs(s_t2, s_t4);
      repeat (4) @(posedge sys_clk);
      for (int ch = 0; ch < 4; ch++) cnt_hi[ch] = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge sys_clk);
         for (int ch = 0; ch < 4; ch++) cnt_hi[ch] += int'(pwm_o[ch]);
      end
      check("pwm0_high_of_20", 32'(cnt_hi[0]), 32'd6);
      check("pwm1_high_of_20", 32'(cnt_hi[1]), 32'd0);
      check("pwm2_high_of_20", 32'(cnt_hi[2]), 32'd20);
      check("pwm3_high_of_20", 32'(cnt_hi[3]), 32'd20);

      // --- Glitch-free duty update ---
      wait_rise(0, ok);
      check("sync_rise_t3", 32'(ok), 32'd1);
      pulses.delete();
      xfer(1'b1, 3'd3, 32'd7, 4'b0011, rd);
      xfer(1'b0, 3'd7, 32'd0, 4'hF, rd);
      check("pending_before_wrap", rd & 32'h3, 32'd1);
      n = 0;
      while ((pulses.size() < 2) && (n < 60)) begin
         @(negedge sys_clk);
         n++;
      end
      check("pulses_seen", 32'(pulses.size() >= 2), 32'd1);
      check("pulse_current_period", 32'((pulses.size() > 0) ? pulses[0] : 0), 32'd3);
      check("pulse_next_period", 32'((pulses.size() > 1) ? pulses[1] : 0), 32'd7);
      xfer(1'b0, 3'd7, 32'd0, 4'hF, rd);
      check("pending_after_wrap", rd & 32'h3, 32'd0);

      // --- Byte selects ---
      run_vecs(s_t4, s_t5);

      // --- Watchdog ---
      repeat (150) @(posedge sys_clk);
      xfer(1'b0, 3'd7, 32'd0, 4'hF, rd);
      check("wdt_not_yet", rd & 32'h2, 32'd0);
      repeat (120) @(posedge sys_clk);
      for (int ch = 0; ch < 4; ch++) begin
         xfer(1'b0, 3'(3 + ch), 32'd0, 4'hF, rd);
         check($sformatf("wdt_duty%0d", ch), rd, 32'd1000);
      end
      xfer(1'b0, 3'd7, 32'd0, 4'hF, rd);
      check("wdt_tripped", rd & 32'h2, 32'd2);
      @(negedge sys_clk);
      check("wdt_pwm_all_high", 32'(pwm_o), 32'hF);
      run_vecs(s_t5, s_end);

      // --- Polarity while disabled ---
      xfer(1'b1, 3'd0, 32'd2, 4'b0001, rd);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("pol_idle_level", 32'(pwm_o), 32'hF);
      xfer(1'b1, 3'd0, 32'd3, 4'b0001, rd);

      // --- Reset mid-period with output high and ack pending ---
      wait_rise(0, ok);
      check("sync_rise_t6", 32'(ok), 32'd1);
      bus.wb_adr_i = {27'd0, 3'd2, 2'b00};
      bus.wb_we_i  = 1'b0;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      @(posedge sys_clk);
      #1;
      $display("%0t RD off=2 ack=%0b rdat=0x%08h (before reset)", $time, bus.wb_ack_o, bus.wb_dat_o);
      check("ack_before_reset", 32'(bus.wb_ack_o), 32'd1);
      check("pwm_before_reset", 32'(pwm_o), 32'h1);
      #2;
      sys_rst = 1'b0;
      #1;
      check("pwm_at_reset", 32'(pwm_o), 32'd0);
      check("ack_at_reset", 32'(bus.wb_ack_o), 32'd0);
      check("dat_at_reset", bus.wb_dat_o, 32'd0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      run_vecs(s_rst, s_t2);
      check("pwm_after_rereset", 32'(pwm_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
